apb_bus_arbiter: RTL and testbench

- Shares the single APB master port between two requesters: the instruction-fetch sequencer (port f_) and the load/store datapath (port d_).
- Arbitrates between them round-robin and runs a standard APB SETUP/ACCESS transfer for the winner.
- Returns read data, a completion pulse and an error flag to the requester that won.
- Sits between the CPU core and the APB slaves (program/data RAM, peripherals).

---
 rtl/apb_bus_arbiter.sv | 177 +++++++++++++++++
 tb/tb_apb_bus_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// apb_bus_arbiter
//
// Purpose:
//   Shares one APB master port between the instruction-fetch sequencer (f_*)
//   and the load/store datapath (d_*). Requests are arbitrated round-robin in
//   IDLE. The winner gets a standard SETUP/ACCESS transfer. Read data, a
//   one-cycle done pulse and an error flag go back to that requester only.
//
// Parameters:
//   ADDR_W   APB address width.
//   DATA_W   APB data width.
//   TIMEOUT  Number of ACCESS cycles with pready low before the transfer is
//            aborted. 0 disables the timeout. Must be at most 65536.
//
// Ports:
//   clk, reset         Rising-edge clock and synchronous active-high reset.
//   f_req/f_addr       Fetch request (always a read). It is held until f_done.
//   f_done/f_rdata/f_err
//                      Fetch completion pulse. f_rdata and f_err are valid
//                      while f_done is high.
//   d_req/d_addr/d_write/d_wdata
//                      Data request. It is held until d_done.
//   d_done/d_rdata/d_err
//                      Data completion pulse. d_rdata and d_err are valid
//                      while d_done is high.
//   paddr/pwrite/pwdata/psel/penable/prdata/pready
//                      APB master port.
//   busy               High whenever the FSM is not in IDLE.
//   state_dbg          Current FSM state (0 IDLE, 1 SETUP, 2 ACCESS).
//
// Handshake:
//   A requester raises req with stable address/data and keeps req high until
//   its done pulse. The request fields are sampled only on the grant edge.
//   done is high for exactly one cycle. In that cycle the FSM is already back
//   in IDLE, and the requester being completed is ignored by arbitration on
//   that edge because its req is still high.
// -----------------------------------------------------------------------------
module apb_bus_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_done,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_err,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_write,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  output logic              psel,
  output logic              penable,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Value of wait_cnt at which the ACCESS edge aborts the transfer.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic        last_grant_d;  // 1: the data port won the last grant
  logic        owner_d;       // 1: the transfer in flight belongs to the data port
  logic [15:0] wait_cnt;

  logic f_ok, d_ok, grant_f, grant_d, timeout_hit;

  // A requester whose done pulse is high right now still holds req high.
  // Masking it here prevents that request from being issued a second time.
  assign f_ok    = f_req & ~f_done;
  assign d_ok    = d_req & ~d_done;
  // On a tie, the port that did not win last time gets the grant.
  assign grant_f = f_ok & (~d_ok | last_grant_d);
  assign grant_d = d_ok & ~grant_f;

  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == TO_LAST);

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
      owner_d      <= 1'b0;
      wait_cnt     <= 16'd0;
      f_done       <= 1'b0;
      f_rdata      <= '0;
      f_err        <= 1'b0;
      d_done       <= 1'b0;
      d_rdata      <= '0;
      d_err        <= 1'b0;
      paddr        <= '0;
      pwrite       <= 1'b0;
      pwdata       <= '0;
      psel         <= 1'b0;
      penable      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      f_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_f || grant_d) begin
            psel         <= 1'b1;
            penable      <= 1'b0;
            busy         <= 1'b1;
            owner_d      <= grant_d;
            last_grant_d <= grant_d;
            wait_cnt     <= 16'd0;
            state        <= SETUP;
            if (grant_f) begin
              paddr  <= f_addr;
              pwrite <= 1'b0;
              pwdata <= '0;
            end else begin
              paddr  <= d_addr;
              pwrite <= d_write;
              pwdata <= d_wdata;
            end
          end
        end

        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end

        ACCESS: begin
          if (pready || timeout_hit) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
            // On a timeout, read data is forced to 0. prdata is read only
            // when the slave is ready.
            if (owner_d) begin
              d_done  <= 1'b1;
              d_err   <= ~pready;
              d_rdata <= (pready && !pwrite) ? prdata : '0;
            end else begin
              f_done  <= 1'b1;
              f_err   <= ~pready;
              f_rdata <= pready ? prdata : '0;
            end
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_bus_arbiter
//
// Directed bench for apb_bus_arbiter. TIMEOUT is set to 4 here.
// Timing convention: grant_edge is the first rising edge that sees the
// request in IDLE. Outputs are sampled 1 ns after each edge. Cycle k is the
// sample taken after edge (grant_edge + k - 1). So k=1 shows psel, k=2 shows
// penable, and k=3 shows done for a zero-wait slave.
// -----------------------------------------------------------------------------
module tb_apb_bus_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          f_req, d_req, d_write, pready;
  logic [AW-1:0] f_addr, d_addr;
  logic [DW-1:0] d_wdata, prdata;
  logic          f_done, f_err, d_done, d_err;
  logic [DW-1:0] f_rdata, d_rdata, pwdata;
  logic [AW-1:0] paddr;
  logic          pwrite, psel, penable, busy;
  logic [1:0]    state_dbg;

  int n_vec = 0;
  int n_err = 0;

  apb_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_addr(d_addr), .d_write(d_write), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    n_vec++; if ({psel, penable, busy, f_done, d_done, f_err, d_err, pwrite} !== 8'h00) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 00000000",
                        {psel, penable, busy, f_done, d_done, f_err, d_err, pwrite}); end
    n_vec++; if ({paddr, pwdata, f_rdata, d_rdata} !== 64'h0) begin
      n_err++; $display("FAIL reset_data: got %h want 0", {paddr, pwdata, f_rdata, d_rdata}); end
    n_vec++; if (state_dbg !== 2'd0) begin
      n_err++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_fetch;
    f_addr = 16'h0010; prdata = 16'hA5A5; pready = 1'b1; f_req = 1'b1;
    tick(); // k=1
    n_vec++; if ({psel, penable, pwrite, busy} !== 4'b1001) begin
      n_err++; $display("FAIL fetch_k1 psel/pen/pwrite/busy: got %b want 1001",
                        {psel, penable, pwrite, busy}); end
    n_vec++; if (paddr !== 16'h0010) begin
      n_err++; $display("FAIL fetch_paddr: got %h want 0010", paddr); end
    tick(); // k=2
    n_vec++; if ({psel, penable, f_done} !== 3'b110) begin
      n_err++; $display("FAIL fetch_k2 psel/pen/done: got %b want 110", {psel, penable, f_done}); end
    tick(); // k=3
    n_vec++; if ({f_done, f_err, d_done, psel, penable, busy} !== 6'b100000) begin
      n_err++; $display("FAIL fetch_k3 done/err/ddone/psel/pen/busy: got %b want 100000",
                        {f_done, f_err, d_done, psel, penable, busy}); end
    n_vec++; if (f_rdata !== 16'hA5A5) begin
      n_err++; $display("FAIL fetch_rdata: got %h want a5a5", f_rdata); end
    f_req = 1'b0;
    tick();
    n_vec++; if ({f_done, psel} !== 2'b00) begin
      n_err++; $display("FAIL fetch_after done/psel: got %b want 00", {f_done, psel}); end
  endtask

  task automatic test_write_waits;
    d_addr = 16'h0200; d_write = 1'b1; d_wdata = 16'h1234; pready = 1'b0;
    prdata = 16'hDEAD; d_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k < 6) begin
        n_vec++; if ({psel, penable, d_done} !== {1'b1, (k >= 2), 1'b0}) begin
          n_err++; $display("FAIL write_k%0d psel/pen/done: got %b want %b", k,
                            {psel, penable, d_done}, {1'b1, (k >= 2), 1'b0}); end
        n_vec++; if ({pwrite, pwdata, paddr} !== {1'b1, 16'h1234, 16'h0200}) begin
          n_err++; $display("FAIL write_k%0d bus: got %b/%h/%h want 1/1234/0200", k,
                            pwrite, pwdata, paddr); end
      end else begin
        n_vec++; if ({d_done, d_err, psel, penable, f_done} !== 5'b10000) begin
          n_err++; $display("FAIL write_done done/err/psel/pen/fdone: got %b want 10000",
                            {d_done, d_err, psel, penable, f_done}); end
        n_vec++; if (d_rdata !== 16'h0000) begin
          n_err++; $display("FAIL write_rdata: got %h want 0000", d_rdata); end
        n_vec++; if (f_rdata !== 16'hA5A5) begin
          n_err++; $display("FAIL write_f_rdata_hold: got %h want a5a5", f_rdata); end
      end
      // pready has been low on three ACCESS edges; the slave answers on the next one.
      if (k == 5) pready = 1'b1;
    end
    d_req = 1'b0; d_write = 1'b0;
    tick();
  endtask

  task automatic test_timeout;
    d_addr = 16'h0300; d_write = 1'b0; pready = 1'b0; prdata = 16'hFFFF; d_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k < 6) begin
        n_vec++; if ({psel, penable, d_done} !== {1'b1, (k >= 2), 1'b0}) begin
          n_err++; $display("FAIL timeout_k%0d psel/pen/done: got %b want %b", k,
                            {psel, penable, d_done}, {1'b1, (k >= 2), 1'b0}); end
      end else begin
        n_vec++; if ({d_done, d_err, psel, penable, busy} !== 5'b11000) begin
          n_err++; $display("FAIL timeout_abort done/err/psel/pen/busy: got %b want 11000",
                            {d_done, d_err, psel, penable, busy}); end
        n_vec++; if (d_rdata !== 16'h0000) begin
          n_err++; $display("FAIL timeout_rdata: got %h want 0000", d_rdata); end
      end
    end
    d_req = 1'b0;
    tick();
    // A new request after the abort proceeds normally.
    d_addr = 16'h0304; pready = 1'b1; prdata = 16'h5A5A; d_req = 1'b1;
    tick();
    n_vec++; if ({psel, paddr} !== {1'b1, 16'h0304}) begin
      n_err++; $display("FAIL timeout_next_grant: got %b/%h want 1/0304", psel, paddr); end
    tick();
    tick();
    n_vec++; if ({d_done, d_err, d_rdata} !== {2'b10, 16'h5A5A}) begin
      n_err++; $display("FAIL timeout_next_done: got %b/%b/%h want 1/0/5a5a",
                        d_done, d_err, d_rdata); end
    d_req = 1'b0;
    tick();
  endtask

  // f_req is held high through its done pulse. It must not be issued again
  // on the masked edge, so the next grant comes one cycle later.
  task automatic test_back_to_back;
    logic [7:0] exp_psel;
    logic [7:0] exp_fdone;
    exp_psel  = 8'b0110_0110;
    exp_fdone = 8'b1000_1000;
    f_addr = 16'h0020; pready = 1'b1; prdata = 16'h1357; f_req = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      n_vec++; if ({psel, f_done} !== {exp_psel[k], exp_fdone[k]}) begin
        n_err++; $display("FAIL b2b_k%0d psel/fdone: got %b want %b", k,
                          {psel, f_done}, {exp_psel[k], exp_fdone[k]}); end
      if (k == 5) f_req = 1'b0;
    end
    n_vec++; if ({f_rdata, f_err} !== {16'h1357, 1'b0}) begin
      n_err++; $display("FAIL b2b_rdata: got %h/%b want 1357/0", f_rdata, f_err); end
    tick();
  endtask

  task automatic test_contention;
    int nf, nd;
    nf = 0; nd = 0;
    reset = 1'b1;
    f_addr = 16'h0100; d_addr = 16'h0200; d_write = 1'b0;
    pready = 1'b1; prdata = 16'hC0DE; f_req = 1'b1; d_req = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_vec++; if ({psel, penable, f_done, d_done} !==
                   {(k % 3 != 0), (k % 3 == 2), (k % 6 == 3), (k % 6 == 0)}) begin
        n_err++; $display("FAIL contend_k%0d psel/pen/fdone/ddone: got %b want %b", k,
                          {psel, penable, f_done, d_done},
                          {(k % 3 != 0), (k % 3 == 2), (k % 6 == 3), (k % 6 == 0)}); end
      if (k % 3 == 1) begin
        n_vec++; if (paddr !== ((k % 6 == 1) ? 16'h0100 : 16'h0200)) begin
          n_err++; $display("FAIL contend_k%0d grant paddr: got %h want %h", k, paddr,
                            (k % 6 == 1) ? 16'h0100 : 16'h0200); end
      end
      if (f_done) nf++;
      if (d_done) nd++;
    end
    n_vec++; if ({nf, nd} !== {32'd2, 32'd2}) begin
      n_err++; $display("FAIL contend_counts: got f=%0d d=%0d want f=2 d=2", nf, nd); end
    n_vec++; if ({f_rdata, d_rdata} !== {16'hC0DE, 16'hC0DE}) begin
      n_err++; $display("FAIL contend_rdata: got %h/%h want c0de/c0de", f_rdata, d_rdata); end
    f_req = 1'b0; d_req = 1'b0;
    tick();
    n_vec++; if ({psel, busy} !== 2'b00) begin
      n_err++; $display("FAIL contend_idle psel/busy: got %b want 00", {psel, busy}); end
  endtask

  task automatic test_reset_mid;
    f_addr = 16'h0040; pready = 1'b0; f_req = 1'b1;
    tick();
    tick();
    n_vec++; if ({psel, penable} !== 2'b11) begin
      n_err++; $display("FAIL rstmid_access psel/pen: got %b want 11", {psel, penable}); end
    reset = 1'b1;
    tick();
    n_vec++; if ({psel, penable, busy, f_done, d_done, state_dbg} !== 7'b0) begin
      n_err++; $display("FAIL rstmid_abort psel/pen/busy/fdone/ddone/state: got %b want 0000000",
                        {psel, penable, busy, f_done, d_done, state_dbg}); end
    reset = 1'b0; pready = 1'b1; prdata = 16'h7777;
    tick();
    n_vec++; if ({psel, penable, paddr} !== {2'b10, 16'h0040}) begin
      n_err++; $display("FAIL rstmid_regrant: got %b/%h want 10/0040", {psel, penable}, paddr); end
    tick();
    tick();
    n_vec++; if ({f_done, f_err, f_rdata} !== {2'b10, 16'h7777}) begin
      n_err++; $display("FAIL rstmid_done: got %b/%b/%h want 1/0/7777", f_done, f_err, f_rdata); end
    f_req = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; f_req = 1'b0; d_req = 1'b0; d_write = 1'b0; pready = 1'b0;
    f_addr = '0; d_addr = '0; d_wdata = '0; prdata = '0;
    test_reset();
    test_single_fetch();
    test_write_waits();
    test_timeout();
    test_back_to_back();
    test_contention();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
